// File: rtl/uart_pkt_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART packet parser:
//   - parser FSM state encoding (HUNT -> ID -> LEN -> DATA -> CHK -> FOOT)
//   - coded error values reported on o_err_code
//   - chk_next(): one step of the running frame checksum
// -----------------------------------------------------------------------------
package uart_pkt_pkg;

  // Parser states, kept as plain 3-bit constants for legacy tool compatibility.
  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_FOOT = 3'd5;

  // Error codes qualified by o_err_valid.
  localparam logic [2:0] ERR_CHK  = 3'd1;  // checksum mismatch
  localparam logic [2:0] ERR_FOOT = 3'd2;  // bad footer byte
  localparam logic [2:0] ERR_TMO  = 3'd3;  // inter-byte timeout
  localparam logic [2:0] ERR_ID   = 3'd4;  // ID not in table
  localparam logic [2:0] ERR_LEN  = 3'd5;  // LEN of 0 or above MAX_PAYLOAD
  localparam logic [2:0] ERR_OVF  = 3'd6;  // output still occupied, packet dropped

  // mode 0: XOR accumulate, mode 1: 8-bit sum (wraps mod 256).
  function automatic logic [7:0] chk_next(input logic       mode,
                                          input logic [7:0] acc,
                                          input logic [7:0] data);
    return mode ? (acc + data) : (acc ^ data);
  endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// -----------------------------------------------------------------------------
// uart_pkt_timeout
// Inter-byte watchdog. Counts cycles while en is high; clr restarts the count.
// expire pulses for one cycle when the count has reached LIMIT-1 and no clear
// arrives in that same cycle (a clear always wins over expiry).
// Ports:
//   clk     clock
//   rst     synchronous reset, active-high
//   en      count enable (frame in progress and parser enabled)
//   clr     restart the count (byte accepted)
//   expire  one-cycle expiry pulse
// -----------------------------------------------------------------------------
module uart_pkt_timeout #(
  parameter  int LIMIT = 18000,
  localparam int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  assign expire = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_packet_parser_mc.sv
// -----------------------------------------------------------------------------
// uart_packet_parser_mc
// Multi-ID, variable-length UART packet parser.
// Frame: HEADER, ID, LEN, LEN payload bytes, CHK, FOOTER.
// The checksum covers ID, LEN and payload. Good packets are presented on a
// valid/ready output; each failure is a one-cycle coded error pulse.
//
// Optional feature (macro UART_PKT_STATS_EN): adds saturating 16-bit counters
// o_good_cnt (packets loaded to the output) and o_err_cnt (error pulses).
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   i_en         parser enable (0 freezes state, timer and checksum)
//   i_rx_data    received byte
//   i_rx_valid   one-cycle byte strobe
//   o_payload    payload, first byte at [7:0], unused bytes zero
//   o_len        payload length of presented packet
//   o_id_idx     ID_TABLE index of presented packet
//   o_valid      packet presented, held until accepted
//   i_ready      consumer accepts when o_valid && i_ready
//   o_err_code   error code, holds its last value between pulses
//   o_err_valid  one-cycle pulse qualifying o_err_code
//   o_good_cnt   (UART_PKT_STATS_EN only) packets delivered
//   o_err_cnt    (UART_PKT_STATS_EN only) error pulses
// -----------------------------------------------------------------------------
module uart_packet_parser_mc
  import uart_pkt_pkg::*;
#(
  parameter  logic [7:0]           HEADER         = 8'hAA,
  parameter  logic [7:0]           FOOTER         = 8'h55,
  parameter  int                   NUM_IDS        = 4,
  // Entry k lives at [8k+7:8k], so entry 0 (0x0C) is the least significant byte.
  parameter  logic [NUM_IDS*8-1:0] ID_TABLE       = 32'h0F0E0D0C,
  parameter  int                   MAX_PAYLOAD    = 32,
  parameter  int                   CHK_MODE       = 0,
  parameter  int                   TIMEOUT_CYCLES = 18000,
  localparam int                   IW             = $clog2(NUM_IDS) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  output logic [MAX_PAYLOAD*8-1:0] o_payload,
  output logic [7:0]               o_len,
  output logic [IW-1:0]            o_id_idx,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2:0]               o_err_code,
`ifdef UART_PKT_STATS_EN
  output logic [15:0]              o_good_cnt,
  output logic [15:0]              o_err_cnt,
`endif
  output logic                     o_err_valid
);

  logic [2:0]               state_q, state_d;
  logic [7:0]               chk_q;
  logic [7:0]               cnt_q;
  logic [7:0]               len_q;
  logic [IW-1:0]            idx_q;
  logic                     match_q;
  logic [MAX_PAYLOAD*8-1:0] shadow_q;

  logic          byte_ok;
  logic          id_hit;
  logic [IW-1:0] id_hit_idx;
  logic          len_ok;
  logic [7:0]    chk_d;
  logic          tmo_expire;
  logic          err_fire;
  logic [2:0]    err_code;
  logic          do_load;

  assign byte_ok = i_en && i_rx_valid;
  assign len_ok  = (i_rx_data != 8'd0) && (i_rx_data <= 8'(MAX_PAYLOAD));
  assign chk_d   = chk_next(CHK_MODE != 0, chk_q, i_rx_data);

  // Descending scan so the lowest matching table index wins.
  always_comb begin
    id_hit     = 1'b0;
    id_hit_idx = '0;
    for (int k = NUM_IDS - 1; k >= 0; k--) begin
      if (ID_TABLE[8*k +: 8] == i_rx_data) begin
        id_hit     = 1'b1;
        id_hit_idx = IW'(k);
      end
    end
  end

  // The timer only runs inside a frame; any accepted byte restarts it and
  // beats an expiry in the same cycle.
  uart_pkt_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk),
    .rst    (i_rst),
    .en     (i_en && (state_q != ST_HUNT)),
    .clr    (byte_ok),
    .expire (tmo_expire)
  );

  // Next state, error pulse and output-load decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    err_fire = 1'b0;
    err_code = ERR_CHK;
    do_load  = 1'b0;
    if (byte_ok) begin
      case (state_q)
        ST_HUNT: if (i_rx_data == HEADER) state_d = ST_ID;
        ST_ID: begin
          if (id_hit) begin
            state_d = ST_LEN;
          end else begin
            err_fire = 1'b1;
            err_code = ERR_ID;
            state_d  = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (len_ok) begin
            state_d = ST_DATA;
          end else begin
            err_fire = 1'b1;
            err_code = ERR_LEN;
            state_d  = ST_HUNT;
          end
        end
        ST_DATA: if (cnt_q + 8'd1 == len_q) state_d = ST_CHK;
        ST_CHK:  state_d = ST_FOOT;
        ST_FOOT: begin
          state_d = ST_HUNT;
          if (i_rx_data != FOOTER) begin
            err_fire = 1'b1;
            err_code = ERR_FOOT;
          end else if (!match_q) begin
            err_fire = 1'b1;
            err_code = ERR_CHK;
          end else if (o_valid && !i_ready) begin
            // Previous packet not yet consumed: drop the new one.
            err_fire = 1'b1;
            err_code = ERR_OVF;
          end else begin
            do_load = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (tmo_expire) begin
      err_fire = 1'b1;
      err_code = ERR_TMO;
      state_d  = ST_HUNT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the payload shadow is a plain register bank, not a RAM, so it is
      // reset along with everything else; a mid-frame reset simply discards it.
      state_q     <= ST_HUNT;
      chk_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      shadow_q    <= '0;
      o_payload   <= '0;
      o_len       <= '0;
      o_id_idx    <= '0;
      o_valid     <= 1'b0;
      o_err_code  <= '0;
      o_err_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_err_valid <= err_fire;
      if (err_fire) o_err_code <= err_code;

      if (byte_ok) begin
        case (state_q)
          ST_HUNT: begin
            if (i_rx_data == HEADER) begin
              chk_q    <= '0;
              cnt_q    <= '0;
              shadow_q <= '0;
            end
          end
          ST_ID: begin
            chk_q <= chk_d;
            idx_q <= id_hit_idx;
          end
          ST_LEN: begin
            chk_q <= chk_d;
            len_q <= i_rx_data;
          end
          ST_DATA: begin
            chk_q <= chk_d;
            cnt_q <= cnt_q + 8'd1;
            for (int b = 0; b < MAX_PAYLOAD; b++) begin
              if (cnt_q == 8'(b)) shadow_q[8*b +: 8] <= i_rx_data;
            end
          end
          ST_CHK:  match_q <= (i_rx_data == chk_q);
          default: ;
        endcase
      end

      // A load in the handshake cycle replaces the accepted packet, so
      // o_valid stays high.
      if (do_load) begin
        o_payload <= shadow_q;
        o_len     <= len_q;
        o_id_idx  <= idx_q;
        o_valid   <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef UART_PKT_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_good_cnt <= '0;
      o_err_cnt  <= '0;
    end else begin
      if (do_load && (o_good_cnt != 16'hFFFF)) o_good_cnt <= o_good_cnt + 16'd1;
      if (err_fire && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_packet_parser_mc.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_parser_mc
// Directed and randomized bench for uart_packet_parser_mc. Expected results
// come from a frame-level reference model (predict) that interprets a whole
// byte sequence by the framing rules.
// -----------------------------------------------------------------------------
module tb_uart_packet_parser_mc;

  localparam int MAXP    = 32;
  localparam int TIMEOUT = 18000;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         ready;
  logic [255:0] payload;
  logic [7:0]   len;
  logic [2:0]   id_idx;
  logic         valid;
  logic [2:0]   err_code;
  logic         err_valid;

  // Second instance in checksum-sum mode with its own byte stream.
  logic [7:0]   rx_data2;
  logic         rx_valid2;
  logic [255:0] payload2;
  logic [7:0]   len2;
  logic [2:0]   id_idx2;
  logic         valid2;
  logic [2:0]   err_code2;
  logic         err_valid2;

`ifdef UART_PKT_STATS_EN
  logic [15:0] good_cnt, err_cnt, good_cnt2, err_cnt2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] ids [4] = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};

  always #5 clk = ~clk;

  uart_packet_parser_mc u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_payload   (payload),
    .o_len       (len),
    .o_id_idx    (id_idx),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_err_code  (err_code),
`ifdef UART_PKT_STATS_EN
    .o_good_cnt  (good_cnt),
    .o_err_cnt   (err_cnt),
`endif
    .o_err_valid (err_valid)
  );

  uart_packet_parser_mc #(.CHK_MODE(1)) u_dut_sum (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (1'b1),
    .i_rx_data   (rx_data2),
    .i_rx_valid  (rx_valid2),
    .o_payload   (payload2),
    .o_len       (len2),
    .o_id_idx    (id_idx2),
    .o_valid     (valid2),
    .i_ready     (1'b1),
    .o_err_code  (err_code2),
`ifdef UART_PKT_STATS_EN
    .o_good_cnt  (good_cnt2),
    .o_err_cnt   (err_cnt2),
`endif
    .o_err_valid (err_valid2)
  );

  task automatic check(input string tag, input logic [255:0] observed,
                       input logic [255:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_chk(input bq_t fr, input int plen, input bit sum_mode);
    int acc = 0;
    for (int i = 1; i <= plen + 2; i++)
      acc = sum_mode ? (acc + int'(fr[i])) % 256 : (acc ^ int'(fr[i]));
    return 8'(acc);
  endfunction

  // Interprets one frame starting at HEADER; code 0 means a good packet.
  function automatic void predict(input bq_t fr, input bit sum_mode, output int code,
                                  output logic [255:0] pl, output int plen, output int pidx);
    code = 0; pl = '0; plen = 0; pidx = -1;
    for (int k = 0; k < 4; k++) if (fr[1] == ids[k] && pidx < 0) pidx = k;
    if (pidx < 0) begin code = 4; return; end
    plen = int'(fr[2]);
    if (plen == 0 || plen > MAXP) begin code = 5; return; end
    if (fr[plen + 4] != 8'h55)                        code = 2;
    else if (fr[plen + 3] != model_chk(fr, plen, sum_mode)) code = 1;
    else for (int i = 0; i < plen; i++) pl[8*i +: 8] = fr[3 + i];
  endfunction

  function automatic bq_t good_frame(input logic [7:0] id, input bq_t pl, input bit sum_mode);
    bq_t fr;
    fr.push_back(8'hAA);
    fr.push_back(id);
    fr.push_back(8'(pl.size()));
    foreach (pl[i]) fr.push_back(pl[i]);
    fr.push_back(model_chk(fr, pl.size(), sum_mode));
    fr.push_back(8'h55);
    return fr;
  endfunction

  // Random frame containing only the bytes the parser will consume.
  function automatic bq_t rand_frame();
    bq_t fr;
    int  r;
    int  plen;
    logic [7:0] c;
    fr.push_back(8'hAA);
    r = $urandom_range(0, 9);
    fr.push_back((r == 0) ? 8'(8'h10 + $urandom_range(0, 100)) : ids[$urandom_range(0, 3)]);
    if (r == 0) return fr;
    r = $urandom_range(0, 9);
    plen = (r == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(33, 255))
                    : $urandom_range(1, MAXP);
    fr.push_back(8'(plen));
    if (r == 0) return fr;
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom_range(0, 255)));
    c = model_chk(fr, plen, 1'b0);
    if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
    fr.push_back(c);
    fr.push_back(($urandom_range(0, 4) == 0) ? 8'(8'h55 ^ (1 << $urandom_range(0, 7))) : 8'h55);
    return fr;
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte2(input logic [7:0] b);
    rx_data2 = b; rx_valid2 = 1'b1;
    @(negedge clk);
    rx_valid2 = 1'b0;
  endtask

  task automatic send_q(input bq_t fr);
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic expect_good(input string tag, input bq_t fr);
    int code, plen, pidx;
    logic [255:0] pl;
    predict(fr, 1'b0, code, pl, plen, pidx);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_errv"}, err_valid, 0);
    check({tag, "_payload"}, payload, pl);
    check({tag, "_len"}, len, plen);
    check({tag, "_idx"}, id_idx, pidx);
  endtask

  task automatic expect_err(input string tag, input int code);
    check({tag, "_errv"}, err_valid, 1);
    check({tag, "_code"}, err_code, code);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bq_t fa, fb, fc, fr;
    int  code, plen, pidx, k, nerr;
    logic [255:0] pl;

    rst = 1'b1; en = 1'b1; ready = 1'b0;
    rx_data = '0; rx_valid = 1'b0; rx_data2 = '0; rx_valid2 = 1'b0;
    idle(3);
    check("rst_valid", valid, 0);
    check("rst_errv", err_valid, 0);
    check("rst_code", err_code, 0);
    check("rst_payload", payload, 0);
    check("rst_len", len, 0);
    check("rst_idx", id_idx, 0);
    rst = 1'b0;
    idle(2);

    // 1: basic frame, latency and hold
    fa = good_frame(8'h0C, '{8'h11, 8'h22, 8'h33}, 1'b0);
    check("t1_chkbyte", fa[6], 8'h0F);
    for (int i = 0; i < 7; i++) send_byte(fa[i]);
    check("t1_before_footer", valid, 0);
    send_byte(fa[7]);
    expect_good("t1", fa);
    check("t1_payload_lo", payload[23:0], 24'h332211);
    idle(3);
    check("t1_held", valid, 1);
    check("t1_held_payload", payload[23:0], 24'h332211);
    ready = 1'b1;
    idle(1);
    check("t1_drop", valid, 0);

    // 2: checksum error, then sum mode on the second instance
    fr = fa; fr[6] = 8'h00;
    send_q(fr);
    expect_err("t2_chk", 1);
    check("t2_no_valid", valid, 0);
    idle(1);
    check("t2_pulse_1cyc", err_valid, 0);
    check("t2_code_hold", err_code, 1);
    fr = good_frame(8'h0C, '{8'h11, 8'h22, 8'h33}, 1'b1);
    check("t2_sum_chk", fr[6], 8'h75);
    foreach (fr[i]) send_byte2(fr[i]);
    check("t2_sum_valid", valid2, 1);
    check("t2_sum_payload", payload2[23:0], 24'h332211);
    foreach (fa[i]) send_byte2(fa[i]);
    check("t2_sum_xorchk_errv", err_valid2, 1);
    check("t2_sum_xorchk_code", err_code2, 1);

    // 3: unknown ID and bad LEN boundaries
    send_byte(8'hAA); send_byte(8'h07);
    expect_err("t3_id", 4);
    send_byte(8'hAA); send_byte(8'h0D); send_byte(8'h00);
    expect_err("t3_len0", 5);
    send_byte(8'hAA); send_byte(8'h0D); send_byte(8'h21);
    expect_err("t3_len33", 5);
    fr = good_frame(8'h0F, '{8'h01, 8'hAA, 8'h55}, 1'b0);  // header/footer values as data
    send_q(fr);
    expect_good("t3_after", fr);
    idle(1);
    fr = '{};
    for (int i = 0; i < MAXP; i++) fr.push_back(8'(i * 7 + 1));
    fr = good_frame(8'h0E, fr, 1'b0);
    send_q(fr);
    expect_good("t3_max", fr);
    idle(1);

    // 4: timeout after payload byte 2
    fr = good_frame(8'h0D, '{8'h11, 8'h22, 8'h33}, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    k = 0;
    while (!err_valid && k < TIMEOUT + 2000) begin
      @(negedge clk);
      k++;
    end
    check("t4_tmo_cycles", k, TIMEOUT);
    expect_err("t4_tmo", 3);
    send_q(fr);
    expect_good("t4_after", fr);
    idle(1);

    // 5: overflow and completion in the handshake cycle
    ready = 1'b0;
    fa = good_frame(8'h0C, '{8'h01, 8'h02}, 1'b0);
    fb = good_frame(8'h0D, '{8'h99}, 1'b0);
    fc = good_frame(8'h0E, '{8'hC1, 8'hC2, 8'hC3}, 1'b0);
    send_q(fa);
    expect_good("t5_a", fa);
    send_q(fb);
    expect_err("t5_ovf", 6);
    check("t5_a_kept", payload, 256'h0201);
    check("t5_a_valid", valid, 1);
    for (int i = 0; i < 7; i++) send_byte(fc[i]);
    ready = 1'b1;
    send_byte(fc[7]);
    ready = 1'b0;
    expect_good("t5_c", fc);
    idle(2);
    check("t5_c_held", valid, 1);
    ready = 1'b1;
    idle(1);
    check("t5_c_drop", valid, 0);

    // 6: enable low mid-frame, then reset mid-DATA
    fr = good_frame(8'h0E, '{8'h11, 8'h22}, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(fr[i]);
    en = 1'b0;
    send_byte(8'h77);  // must be ignored
    nerr = 0;
    repeat (50000) begin
      @(negedge clk);
      if (err_valid) nerr++;
    end
    check("t6_no_tmo", nerr, 0);
    en = 1'b1;
    for (int i = 4; i < 7; i++) send_byte(fr[i]);
    expect_good("t6_en", fr);
    idle(1);
    send_byte(8'hAA); send_byte(8'h0C); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    idle(1);
    check("t6_rst_payload", payload, 0);
    check("t6_rst_valid", valid, 0);
    check("t6_rst_code", err_code, 0);
    check("t6_rst_len", len, 0);
    rst = 1'b0;
    fr = good_frame(8'h0F, '{8'h5A}, 1'b0);
    send_q(fr);
    expect_good("t6_after_rst", fr);
    idle(1);

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hAA) junk = 8'h00;
        send_byte(junk);
        check("rnd_junk_errv", err_valid, 0);
      end
      fr = rand_frame();
      predict(fr, 1'b0, code, pl, plen, pidx);
      foreach (fr[i]) begin
        idle($urandom_range(0, 2));
        send_byte(fr[i]);
      end
      if (code != 0) begin
        expect_err("rnd_err", code);
        check("rnd_err_novalid", valid, 0);
      end else begin
        expect_good("rnd_good", fr);
      end
      idle(1);
      check("rnd_idle_valid", valid, 0);
      check("rnd_idle_errv", err_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
